// File: rtl/mux_rr_rafaga.sv
// Purpose : merges NUM_CANALES show-ahead FIFO heads onto one registered word
//           stream, arbitrated round-robin with bounded bursts or by a fixed selector.
// Latency : one cycle from pop[g] to valido/salida; one word per cycle sustained.
// Backpres: lleno_destino=1 (or enb=0) suppresses every pop; valido drops, data holds.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   enb                 block enable
//   modo, selector      0 = round-robin with bursts, 1 = fixed channel 'selector'
//   entradas, vacios    upstream FIFO heads (channel c at [c*DATA_BITS +: DATA_BITS]) and empty flags
//   lleno_destino       destination FIFO full
//   pop                 combinational one-hot pop towards the granted FIFO (or zero)
//   salida, valido      registered output word and its new-word strobe
//   canal               channel index the word in salida came from
module mux_rr_rafaga #(
    parameter int DATA_BITS   = 4,
    parameter int NUM_CANALES = 4,
    parameter int MAX_RAFAGA  = 2,
    localparam int SEL_W      = (NUM_CANALES <= 2) ? 1 : $clog2(NUM_CANALES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enb,
    input  logic                             modo,
    input  logic [SEL_W-1:0]                 selector,
    input  logic [NUM_CANALES*DATA_BITS-1:0] entradas,
    input  logic [NUM_CANALES-1:0]           vacios,
    input  logic                             lleno_destino,
    output logic [NUM_CANALES-1:0]           pop,
    output logic [DATA_BITS-1:0]             salida,
    output logic                             valido,
    output logic [SEL_W-1:0]                 canal
);

    localparam int CNT_W = $clog2(MAX_RAFAGA + 1);

    // Channel count widened by one bit so that modular wrap and range checks
    // never compare against a value the operand cannot hold.
    localparam logic [SEL_W:0]   N_EXT      = (SEL_W + 1)'(NUM_CANALES);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_RAFAGA);
    localparam logic [SEL_W-1:0] ULTIMO_RST = SEL_W'(NUM_CANALES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] salida_q, salida_d;
    logic                 valido_q, valido_d;
    logic [SEL_W-1:0]     canal_q,  canal_d;
    logic [SEL_W-1:0]     ultimo_q, ultimo_d;
    logic [CNT_W-1:0]     cuenta_q, cuenta_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                 permitir;
    logic                 hay_grant_rr;
    logic [SEL_W-1:0]     grant_rr;
    logic                 hay_grant_fijo;
    logic [SEL_W-1:0]     grant_fijo;
    logic                 hay_grant;
    logic [SEL_W-1:0]     grant;
    logic [SEL_W:0]       cand;
    logic [DATA_BITS-1:0] dato_sel;

    // Reset is folded in here so pop is quiet during reset regardless of the
    // other inputs.
    assign permitir = !reset && enb && !lleno_destino;

    // Round-robin: stay on the current channel while its burst budget lasts
    // and it still has data; otherwise scan forward from ultimo+1, wrapping,
    // with ultimo itself visited last. Visiting ultimo last is what lets a
    // lone non-empty channel keep streaming after its burst expires.
    always_comb begin
        hay_grant_rr = 1'b0;
        grant_rr     = ultimo_q;
        cand         = '0;
        if ((cuenta_q < MAX_CNT) && !vacios[ultimo_q]) begin
            hay_grant_rr = 1'b1;
            grant_rr     = ultimo_q;
        end else begin
            for (int i = 1; i <= NUM_CANALES; i++) begin
                cand = {1'b0, ultimo_q} + (SEL_W + 1)'(i);
                if (cand >= N_EXT) begin
                    cand = cand - N_EXT;
                end
                if (!hay_grant_rr && !vacios[cand[SEL_W-1:0]]) begin
                    hay_grant_rr = 1'b1;
                    grant_rr     = cand[SEL_W-1:0];
                end
            end
        end
    end

    // Fixed selector: a selector beyond the last channel (possible when
    // NUM_CANALES is not a power of two) never grants.
    always_comb begin
        hay_grant_fijo = 1'b0;
        grant_fijo     = selector;
        if ({1'b0, selector} < N_EXT) begin
            if (!vacios[selector]) begin
                hay_grant_fijo = 1'b1;
            end
        end
    end

    assign hay_grant = permitir && (modo ? hay_grant_fijo : hay_grant_rr);
    assign grant     = modo ? grant_fijo : grant_rr;

    // One-hot pop and the data word of the granted channel.
    always_comb begin
        pop      = '0;
        dato_sel = '0;
        for (int c = 0; c < NUM_CANALES; c++) begin
            if (grant == SEL_W'(c)) begin
                pop[c]   = hay_grant;
                dato_sel = entradas[c*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    // Without a grant only valido changes; everything else holds, so a
    // stalled or disabled cycle does not disturb the burst in progress.
    always_comb begin
        salida_d = salida_q;
        valido_d = 1'b0;
        canal_d  = canal_q;
        ultimo_d = ultimo_q;
        cuenta_d = cuenta_q;
        if (hay_grant) begin
            salida_d = dato_sel;
            valido_d = 1'b1;
            canal_d  = grant;
            ultimo_d = grant;
            // A re-grant after the burst budget is spent (lone channel)
            // starts a fresh burst rather than saturating.
            if ((grant == ultimo_q) && (cuenta_q < MAX_CNT)) begin
                cuenta_d = cuenta_q + CNT_W'(1);
            end else begin
                cuenta_d = CNT_W'(1);
            end
        end
    end

    // Reset state makes the first scan start at channel 0: ultimo points at
    // the last channel with its burst budget exhausted.
    always_ff @(posedge clk) begin
        if (reset) begin
            salida_q <= '0;
            valido_q <= 1'b0;
            canal_q  <= '0;
            ultimo_q <= ULTIMO_RST;
            cuenta_q <= MAX_CNT;
        end else begin
            salida_q <= salida_d;
            valido_q <= valido_d;
            canal_q  <= canal_d;
            ultimo_q <= ultimo_d;
            cuenta_q <= cuenta_d;
        end
    end

    assign salida = salida_q;
    assign valido = valido_q;
    assign canal  = canal_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_pop_onehot : assert property (@(posedge clk) $onehot0(pop));
    a_pop_vacio  : assert property (@(posedge clk) (pop & vacios) == '0);

endmodule

// File: tb/tb_mux_rr_rafaga.sv
module tb_mux_rr_rafaga;

    logic        clk;
    logic        reset;
    logic        enb;
    logic        modo;
    logic [1:0]  selector;
    logic [15:0] entradas;
    logic [3:0]  vacios;
    logic        lleno_destino;
    logic [3:0]  pop;
    logic [3:0]  salida;
    logic        valido;
    logic [1:0]  canal;

    int tests;
    int fallos;

    typedef struct {
        logic       rst;
        logic       en;
        logic       md;
        logic [1:0] sel;
        logic [3:0] vac;
        logic       lleno;
        logic       chk_q;   // registered outputs are known (not the very first cycle)
        logic [3:0] e_pop;
        logic       e_val;
        logic [3:0] e_sal;
        logic [1:0] e_can;
    } vec_t;

    vec_t tabla [25];

    mux_rr_rafaga #(
        .DATA_BITS  (4),
        .NUM_CANALES(4),
        .MAX_RAFAGA (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enb          (enb),
        .modo         (modo),
        .selector     (selector),
        .entradas     (entradas),
        .vacios       (vacios),
        .lleno_destino(lleno_destino),
        .pop          (pop),
        .salida       (salida),
        .valido       (valido),
        .canal        (canal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nombre, input string grupo, input int idx,
                       input logic [3:0] actual, input logic [3:0] esperado);
        tests++;
        if (actual !== esperado) begin
            fallos++;
            $display("FAIL %s %s[%0d]: got %h, expected %h", nombre, grupo, idx, actual, esperado);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, let the combinational
    // pop settle, then check pop plus the registered outputs from the last edge.
    task automatic aplicar(input vec_t v, input string grupo, input int idx);
        @(negedge clk);
        reset         = v.rst;
        enb           = v.en;
        modo          = v.md;
        selector      = v.sel;
        vacios        = v.vac;
        lleno_destino = v.lleno;
        #1;
        chk("pop", grupo, idx, pop, v.e_pop);
        if (v.chk_q) begin
            chk("valido", grupo, idx, {3'b000, valido}, {3'b000, v.e_val});
            chk("salida", grupo, idx, salida, v.e_sal);
            chk("canal",  grupo, idx, {2'b00, canal}, {2'b00, v.e_can});
        end
    endtask

    task automatic paso(input string grupo, input int idx,
                        input logic rst, input logic en, input logic md, input logic [1:0] sel,
                        input logic [3:0] vac, input logic lleno,
                        input logic [3:0] e_pop, input logic e_val,
                        input logic [3:0] e_sal, input logic [1:0] e_can);
        vec_t v;
        v = '{rst, en, md, sel, vac, lleno, 1'b1, e_pop, e_val, e_sal, e_can};
        aplicar(v, grupo, idx);
    endtask

    initial begin
        tests         = 0;
        fallos        = 0;
        reset         = 1'b1;
        enb           = 1'b1;
        modo          = 1'b0;
        selector      = 2'd0;
        entradas      = 16'hB6A2;   // ch3=B ch2=6 ch1=A ch0=2
        vacios        = 4'b0000;
        lleno_destino = 1'b0;

        //            rst en md sel vac      ll chk  pop     v  sal    can
        // reset held two cycles
        tabla[0]  = '{1, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 4'h0, 2'd0};
        tabla[1]  = '{1, 1, 0, 0, 4'b0000, 0, 1, 4'b0000, 0, 4'h0, 2'd0};
        // round-robin, bursts of two, all non-empty
        tabla[2]  = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0001, 0, 4'h0, 2'd0};
        tabla[3]  = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0001, 1, 4'h2, 2'd0};
        tabla[4]  = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0010, 1, 4'h2, 2'd0};
        tabla[5]  = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0010, 1, 4'hA, 2'd1};
        tabla[6]  = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0100, 1, 4'hA, 2'd1};
        tabla[7]  = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0100, 1, 4'h6, 2'd2};
        tabla[8]  = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b1000, 1, 4'h6, 2'd2};
        tabla[9]  = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b1000, 1, 4'hB, 2'd3};
        tabla[10] = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0001, 1, 4'hB, 2'd3};
        // lone channel 2: continuous grants across burst expiry
        tabla[11] = '{0, 1, 0, 0, 4'b1011, 0, 1, 4'b0100, 1, 4'h2, 2'd0};
        tabla[12] = '{0, 1, 0, 0, 4'b1011, 0, 1, 4'b0100, 1, 4'h6, 2'd2};
        tabla[13] = '{0, 1, 0, 0, 4'b1011, 0, 1, 4'b0100, 1, 4'h6, 2'd2};
        tabla[14] = '{0, 1, 0, 0, 4'b1011, 0, 1, 4'b0100, 1, 4'h6, 2'd2};
        // all non-empty again, walk round to the first ch1 grant
        tabla[15] = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b1000, 1, 4'h6, 2'd2};
        tabla[16] = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b1000, 1, 4'hB, 2'd3};
        tabla[17] = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0001, 1, 4'hB, 2'd3};
        tabla[18] = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0001, 1, 4'h2, 2'd0};
        tabla[19] = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0010, 1, 4'h2, 2'd0};
        // destination full for three cycles
        tabla[20] = '{0, 1, 0, 0, 4'b0000, 1, 1, 4'b0000, 1, 4'hA, 2'd1};
        tabla[21] = '{0, 1, 0, 0, 4'b0000, 1, 1, 4'b0000, 0, 4'hA, 2'd1};
        tabla[22] = '{0, 1, 0, 0, 4'b0000, 1, 1, 4'b0000, 0, 4'hA, 2'd1};
        // released: ch1 finishes its burst, then ch2
        tabla[23] = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0010, 0, 4'hA, 2'd1};
        tabla[24] = '{0, 1, 0, 0, 4'b0000, 0, 1, 4'b0100, 1, 4'hA, 2'd1};

        for (int i = 0; i < 25; i++) begin
            aplicar(tabla[i], "tabla", i);
        end

        // Fixed mode: state after tabla[24] is ultimo=2, cuenta=1, salida=6.
        //       grp     n  rst en md sel vac      ll  pop     v  sal   can
        paso("fijo",   0, 0, 1, 1, 1, 4'b0010, 0, 4'b0000, 1, 4'h6, 2'd2);
        paso("fijo",   1, 0, 1, 1, 1, 4'b0000, 0, 4'b0010, 0, 4'h6, 2'd2);
        paso("fijo",   2, 0, 1, 1, 1, 4'b0000, 0, 4'b0010, 1, 4'hA, 2'd1);
        paso("fijo",   3, 0, 1, 1, 3, 4'b0000, 0, 4'b1000, 1, 4'hA, 2'd1);

        // Back to round-robin mid-burst on ch3 (cuenta=1), then disabled twice.
        paso("disrup", 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 4'hB, 2'd3);
        paso("disrup", 1, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'hB, 2'd3);
        // Held burst state: ch3 gets its second word before moving on.
        paso("disrup", 2, 0, 1, 0, 0, 4'b0000, 0, 4'b1000, 0, 4'hB, 2'd3);
        paso("disrup", 3, 0, 1, 0, 0, 4'b0000, 0, 4'b0001, 1, 4'hB, 2'd3);
        paso("disrup", 4, 0, 1, 0, 0, 4'b0000, 0, 4'b0001, 1, 4'h2, 2'd0);
        paso("disrup", 5, 0, 1, 0, 0, 4'b0000, 0, 4'b0010, 1, 4'h2, 2'd0);
        // Reset one cycle in the middle of the ch1 burst.
        paso("disrup", 6, 1, 1, 0, 0, 4'b0000, 0, 4'b0000, 1, 4'hA, 2'd1);
        // Cleared outputs; arbitration restarts at ch0 instead of finishing ch1.
        paso("disrup", 7, 0, 1, 0, 0, 4'b0000, 0, 4'b0001, 0, 4'h0, 2'd0);
        paso("disrup", 8, 0, 1, 0, 0, 4'b0000, 0, 4'b0001, 1, 4'h2, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fallos);
        $finish;
    end

endmodule

// File: doc/mux_rr_rafaga.md
Name: mux_rr_rafaga

Overview:
- Parametrised, registered successor to the 4-channel combinational mux.
- Merges NUM_CANALES upstream FIFO channels onto one output word stream.
- Selection is either round-robin with a bounded burst length per channel, or a fixed selector.
- Pops the chosen channel's FIFO and honours backpressure from the destination FIFO.

Parameters:
- DATA_BITS, 4: width of each data word.
- NUM_CANALES, 4: number of input channels (>=2, need not be a power of 2).
- MAX_RAFAGA, 2: maximum consecutive words granted to one channel while another channel is non-empty (>=1).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enb, input, 1: block enable.
- modo, input, 1: 0 = round-robin with bursts; 1 = fixed selector.
- selector, input, SEL_W: channel to use when modo=1. SEL_W = max(1, $clog2(NUM_CANALES)).
- entradas, input, NUM_CANALES*DATA_BITS: heads of the upstream FIFOs; channel c occupies bits [c*DATA_BITS +: DATA_BITS].
- vacios, input, NUM_CANALES: upstream FIFO empty flags, bit c for channel c.
- lleno_destino, input, 1: destination FIFO full.
- pop, output, NUM_CANALES: combinational one-hot pop, or zero.
- salida, output, DATA_BITS: registered output word.
- valido, output, 1: salida holds a new word this cycle.
- canal, output, SEL_W: channel index of salida.

Behaviour:
- Upstream FIFOs are show-ahead: the head word is valid whenever vacios[c]=0, and pop[c] high at an edge consumes it.
- Internal state: ultimo (last granted channel, SEL_W bits) and cuenta (consecutive grants to ultimo, 0..MAX_RAFAGA).
- Reset values: salida=0, valido=0, canal=0, ultimo=NUM_CANALES-1, cuenta=MAX_RAFAGA. pop is forced to 0 while reset=1. reset overrides every other input, including mid-burst.
- No grant when enb=0 or lleno_destino=1. In that case: pop=0, valido<=0, salida/canal/ultimo/cuenta hold.
- Round-robin grant (modo=0):
  - If cuenta<MAX_RAFAGA and vacios[ultimo]=0, grant ultimo.
  - Otherwise grant the first non-empty channel scanning ultimo+1, ultimo+2, ... mod NUM_CANALES, with ultimo checked last.
  - If all channels are empty, no grant.
- Fixed grant (modo=1): grant selector if selector<NUM_CANALES and vacios[selector]=0; otherwise no grant. An out-of-range selector never pops.
- modo and selector are sampled every cycle; a change takes effect on the same cycle's grant decision.
- On a grant to channel g, pop[g]=1 combinationally in that cycle. At the edge:
  - salida<=entradas[g], canal<=g, valido<=1, ultimo<=g.
  - cuenta<=cuenta+1 if g==ultimo and cuenta<MAX_RAFAGA; otherwise cuenta<=1. This covers the case where a lone non-empty channel is re-granted after its burst expires.
- If there is no grant and enb=1 with lleno_destino=0, valido<=0 and all other state holds.
- Latency: one cycle from pop[g] to valido/salida. Throughput: one word per cycle.
- pop must never assert for a channel whose vacios bit is 1, and at most one bit is ever set.

Test Plan (DATA_BITS=4, NUM_CANALES=4, MAX_RAFAGA=2):
1. Reset: reset=1 for 2 cycles with vacios=0000 and enb=1 -> pop=0000, valido=0, salida=0, canal=0. Reset released -> first pop=0001.
2. Round-robin, all non-empty, entradas={B,6,A,2} (ch3..ch0), held -> pop sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001. salida one cycle later is 2,2,A,A,6,6,B,B.
3. Lone channel: vacios=1011 -> pop=0100 every cycle (no gap after the burst expires), canal=2, valido=1 continuously.
4. Backpressure: lleno_destino=1 for 3 cycles after the first ch1 grant -> pop=0000, valido=0 on the following cycle, salida holds A. On release, ch1 is granted once more, then ch2.
5. Fixed mode: modo=1, selector=1, vacios=0010 -> pop=0000, valido=0. Set vacios=0000 -> pop=0010 each cycle. Set selector=3 -> pop=1000 on the same cycle.
6. Mid-burst disruption: enb=0 for 2 cycles -> pop=0000 and state held. Then reset=1 for 1 cycle mid-burst -> outputs cleared, and the next grant is ch0.
